// File: rtl/l2_axi_pkg.sv
// Shared state encodings and AXI constants for the L2-to-AXI bridge.
package l2_axi_pkg;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
endpackage

// File: rtl/l2cache_axi_wser.sv
// Write-line serializer: holds the accepted line and steps one 32-bit word per W handshake.
module l2cache_axi_wser #(
  parameter  int OFFSET_WIDTH = 3,
  localparam int BEATS        = 1 << OFFSET_WIDTH,
  localparam int LW           = 32 * BEATS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [LW-1:0] line_i,
  input  logic          suc_i,
  input  logic          adv_i,
  output logic [31:0]   wdata_o,
  output logic          wlast_o
);
  logic [LW-1:0]           line_q;
  logic [OFFSET_WIDTH-1:0] beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      beat_q <= '0;
    end else if (load_i) begin
      line_q <= line_i;
      beat_q <= '0;
    end else if (adv_i) begin
      beat_q <= wlast_o ? '0 : beat_q + 1'b1;
    end
  end

  // Uncached writes are a single beat carrying the low word only.
  assign wdata_o = suc_i ? line_q[31:0] : line_q[{beat_q, 5'd0} +: 32];
  assign wlast_o = suc_i || (beat_q == OFFSET_WIDTH'(BEATS - 1));
endmodule

// File: rtl/l2cache_axi_bridge.sv
// Bridges L2 line fills/evictions (and uncached single accesses) onto an AXI master.
import l2_axi_pkg::*;

module l2cache_axi_bridge #(
  parameter  int OFFSET_WIDTH = 3,
  localparam int BEATS        = 1 << OFFSET_WIDTH,
  localparam int LW           = 32 * BEATS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   addr_l2cache_mem_r,
  input  logic [31:0]   addr_l2cache_mem_w,
  input  logic [LW-1:0] dout_l2cache_mem,
  input  logic          l2cache_mem_req_r,
  input  logic          l2cache_mem_req_w,
  input  logic          l2cache_mem_rdy,
  input  logic          l2cache_mem_SUC,
  input  logic [3:0]    l2cache_mem_wstrb,
  input  logic [1:0]    l2cache_mem_size,
  output logic [LW-1:0] din_mem_l2cache,
  output logic          mem_l2cache_addrOK_r,
  output logic          mem_l2cache_addrOK_w,
  output logic          mem_l2cache_dataOK,
  output logic [31:0]   araddr,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic          arvalid,
  input  logic          arready,
  input  logic [31:0]   rdata,
  input  logic          rlast,
  input  logic          rvalid,
  output logic          rready,
  output logic [31:0]   awaddr,
  output logic [7:0]    awlen,
  output logic [2:0]    awsize,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  output logic [31:0]   wdata,
  output logic [3:0]    wstrb,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  input  logic          bvalid,
  output logic          bready
);
  localparam int TAGL = OFFSET_WIDTH + 2;

  rd_state_e               r_state_q;
  logic [31:0]             raddr_q;
  logic                    rsuc_q;
  logic [1:0]              rsize_q;
  logic [OFFSET_WIDTH-1:0] rbeat_q;
  logic [LW-1:0]           din_q;

  wr_state_e               w_state_q;
  logic [31:0]             waddr_q;
  logic                    wsuc_q;
  logic [3:0]              wstrb_q;
  logic [1:0]              wsize_q;

  logic w_acc, r_acc, hazard;

  assign w_acc = !rst && l2cache_mem_req_w && (w_state_q == W_IDLE);

  // A read may not overtake a write to the same line, whether already in
  // flight or being accepted in this very cycle.
  assign hazard = ((w_state_q != W_IDLE) &&
                   (waddr_q[31:TAGL] == addr_l2cache_mem_r[31:TAGL])) ||
                  (w_acc && (addr_l2cache_mem_w[31:TAGL] == addr_l2cache_mem_r[31:TAGL]));

  assign r_acc = !rst && l2cache_mem_req_r && (r_state_q == R_IDLE) && !hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rsuc_q    <= 1'b0;
      rsize_q   <= '0;
      rbeat_q   <= '0;
      din_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (r_acc) begin
          raddr_q   <= addr_l2cache_mem_r;
          rsuc_q    <= l2cache_mem_SUC;
          rsize_q   <= l2cache_mem_size;
          r_state_q <= R_AR;
        end
        R_AR: if (arready) r_state_q <= R_DATA;
        R_DATA: if (rvalid) begin
          if (rsuc_q) din_q <= {{(LW-32){1'b0}}, rdata};
          else        din_q[{rbeat_q, 5'd0} +: 32] <= rdata;
          rbeat_q <= rlast ? '0 : rbeat_q + 1'b1;
          if (rlast) r_state_q <= R_DONE;
        end
        R_DONE: if (l2cache_mem_rdy) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wsuc_q    <= 1'b0;
      wstrb_q   <= '0;
      wsize_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (w_acc) begin
          waddr_q   <= addr_l2cache_mem_w;
          wsuc_q    <= l2cache_mem_SUC;
          wstrb_q   <= l2cache_mem_wstrb;
          wsize_q   <= l2cache_mem_size;
          w_state_q <= W_AW;
        end
        W_AW:   if (awready) w_state_q <= W_DATA;
        W_DATA: if (wready && wlast) w_state_q <= W_RESP;
        W_RESP: if (bvalid) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  l2cache_axi_wser #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_wser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_acc),
    .line_i  (dout_l2cache_mem),
    .suc_i   (wsuc_q),
    .adv_i   (wvalid && wready),
    .wdata_o (wdata),
    .wlast_o (wlast)
  );

  assign mem_l2cache_addrOK_r = r_acc;
  assign mem_l2cache_addrOK_w = w_acc;
  assign mem_l2cache_dataOK   = (r_state_q == R_DONE) && l2cache_mem_rdy;
  assign din_mem_l2cache      = din_q;

  assign araddr  = raddr_q;
  assign arlen   = rsuc_q ? 8'd0 : 8'(BEATS - 1);
  assign arsize  = rsuc_q ? {1'b0, rsize_q} : AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (r_state_q == R_AR);
  assign rready  = (r_state_q == R_DATA);

  assign awaddr  = waddr_q;
  assign awlen   = wsuc_q ? 8'd0 : 8'(BEATS - 1);
  assign awsize  = wsuc_q ? {1'b0, wsize_q} : AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (w_state_q == W_AW);
  assign wvalid  = (w_state_q == W_DATA);
  assign wstrb   = wsuc_q ? wstrb_q : 4'hF;
  assign bready  = (w_state_q == W_RESP);
endmodule

// File: tb/tb_l2cache_axi_bridge.sv
// Directed-plus-random bench for l2cache_axi_bridge; the bench plays both the L2 and the AXI slave.
module tb_l2cache_axi_bridge;
  localparam int BEATS = 8;
  localparam int LW    = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr_r = '0, addr_w = '0;
  logic [LW-1:0] dout = '0;
  logic          req_r = 1'b0, req_w = 1'b0, rdy = 1'b0, suc = 1'b0;
  logic [3:0]    strb_in = '0;
  logic [1:0]    size = '0;
  logic [LW-1:0] din;
  logic          addrOK_r, addrOK_w, dataOK;
  logic [31:0]   araddr, awaddr, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic          arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [3:0]    wstrb;
  logic          arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [31:0]   rdata = '0;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  l2cache_axi_bridge #(.OFFSET_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .addr_l2cache_mem_r(addr_r), .addr_l2cache_mem_w(addr_w),
    .dout_l2cache_mem(dout),
    .l2cache_mem_req_r(req_r), .l2cache_mem_req_w(req_w),
    .l2cache_mem_rdy(rdy), .l2cache_mem_SUC(suc),
    .l2cache_mem_wstrb(strb_in), .l2cache_mem_size(size),
    .din_mem_l2cache(din),
    .mem_l2cache_addrOK_r(addrOK_r), .mem_l2cache_addrOK_w(addrOK_w),
    .mem_l2cache_dataOK(dataOK),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_accept(input logic [31:0] a, input bit s, input logic [1:0] sz);
    addr_r = a; suc = s; size = sz; req_r = 1'b1; #1;
    for (int i = 0; i < 40 && addrOK_r !== 1'b1; i++) tick();
    chk("addrOK_r", addrOK_r, 1);
    tick();
    req_r = 1'b0; suc = 1'b0; addr_r = ~a; #1;
  endtask

  task automatic wr_accept(input logic [31:0] a, input bit s, input logic [1:0] sz,
                           input logic [3:0] st, input logic [LW-1:0] line);
    addr_w = a; suc = s; size = sz; strb_in = st; dout = line; req_w = 1'b1; #1;
    for (int i = 0; i < 40 && addrOK_w !== 1'b1; i++) tick();
    chk("addrOK_w", addrOK_w, 1);
    tick();
    req_w = 1'b0; suc = 1'b0; dout = ~line; strb_in = ~st; #1;
  endtask

  // pat: 0 random words, 1 word k = k, 2 every word 0xDEADBEEF
  task automatic rd_body(input logic [31:0] a, input bit s, input logic [1:0] sz,
                         input int rdy_delay, input int abort_beat, input int pat);
    logic [31:0]   w [BEATS];
    logic [LW-1:0] exp_line;
    int n;
    n = s ? 1 : BEATS;
    exp_line = '0;
    for (int k = 0; k < n; k++) begin
      w[k] = (pat == 1) ? k : (pat == 2) ? 32'hDEADBEEF : $urandom;
      exp_line[32*k +: 32] = w[k];
    end
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arlen", arlen, s ? 0 : BEATS - 1);
    chk("arsize", arsize, s ? {1'b0, sz} : 3'd2);
    chk("arburst", arburst, 2'b01);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, a);
    end
    arready = 1'b1; tick(); arready = 1'b0; #1;
    chk("arvalid_drop", arvalid, 0);
    rdy = (rdy_delay == 0);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 1)) begin
        chk("rready_gap", rready, 1);
        tick();
      end
      chk("rready", rready, 1);
      chk("dataOK_early", dataOK, 0);
      rvalid = 1'b1; rdata = w[k]; rlast = (k == n - 1);
      if (k == abort_beat) begin
        rst = 1'b1; #1;
        chk("rst_rready", rready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_dataOK", dataOK, 0);
        chk("rst_din", din, 0);
        rvalid = 1'b0; rlast = 1'b0; rdy = 1'b0;
        tick(); rst = 1'b0; tick();
        chk("post_rst_rready", rready, 0);
        return;
      end
      tick();
      rvalid = 1'b0; rlast = 1'b0; #1;
    end
    for (int i = 0; i < rdy_delay; i++) begin
      chk("dataOK_wait", dataOK, 0);
      chk("din_hold", din, exp_line);
      chk("rready_done", rready, 0);
      tick();
    end
    rdy = 1'b1; #1;
    chk("dataOK", dataOK, 1);
    chk("din", din, exp_line);
    tick();
    chk("dataOK_pulse", dataOK, 0);
    chk("din_after", din, exp_line);
    rdy = 1'b0;
  endtask

  task automatic wr_body(input logic [31:0] a, input bit s, input logic [1:0] sz,
                         input logic [3:0] st, input logic [LW-1:0] line, input bit toggle);
    int n, k, cyc;
    n = s ? 1 : BEATS;
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, a);
    chk("awlen", awlen, s ? 0 : BEATS - 1);
    chk("awsize", awsize, s ? {1'b0, sz} : 3'd2);
    chk("awburst", awburst, 2'b01);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, a);
    end
    awready = 1'b1; tick(); awready = 1'b0; #1;
    k = 0; cyc = 0;
    while (k < n && cyc < 100) begin
      wready = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1)); #1;
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, s ? line[31:0] : line[32*k +: 32]);
      chk("wlast", wlast, k == n - 1);
      chk("wstrb", wstrb, s ? st : 4'hF);
      chk("bready_early", bready, 0);
      if (wready) k++;
      tick(); cyc++;
    end
    wready = 1'b0;
    chk("wbeats", k, n);
  endtask

  task automatic wr_resp(input int bdelay, input bit expect_block);
    #1;
    chk("bready", bready, 1);
    chk("wvalid_off", wvalid, 0);
    for (int i = 0; i < bdelay; i++) begin
      if (expect_block) chk("hz_addrOK_r_resp", addrOK_r, 0);
      tick();
      chk("bready_hold", bready, 1);
    end
    bvalid = 1'b1; #1;
    if (expect_block) chk("hz_addrOK_r_bvalid", addrOK_r, 0);
    tick();
    bvalid = 1'b0; #1;
    chk("bready_idle", bready, 0);
    chk("awvalid_idle", awvalid, 0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [LW-1:0] line, line2;
    logic [31:0]   a, b;
    bit            s;
    logic [1:0]    sz;
    logic [3:0]    st;

    // reset state, including requests held during reset
    req_r = 1'b1; req_w = 1'b1; #1;
    chk("rst_addrOK_r", addrOK_r, 0);
    chk("rst_addrOK_w", addrOK_w, 0);
    chk("rst_arvalid0", arvalid, 0);
    chk("rst_awvalid0", awvalid, 0);
    chk("rst_wvalid0", wvalid, 0);
    chk("rst_rready0", rready, 0);
    chk("rst_bready0", bready, 0);
    chk("rst_dataOK0", dataOK, 0);
    chk("rst_din0", din, 0);
    req_r = 1'b0; req_w = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // cached read, word k = k, rdy already high
    rd_accept(32'h1000, 0, 2'd2);
    rd_body(32'h1000, 0, 2'd2, 0, -1, 1);

    // uncached single read
    rd_accept(32'hBFAF8000, 1, 2'd2);
    rd_body(32'hBFAF8000, 1, 2'd2, 0, -1, 2);

    // read with rdy low for 5 cycles after rlast
    rd_accept(32'h0000_8A40, 0, 2'd2);
    rd_body(32'h0000_8A40, 0, 2'd2, 5, -1, 0);

    // cached write with wready toggling 1,0,1,...
    line = rand_line();
    wr_accept(32'h2000, 0, 2'd2, 4'h3, line);
    wr_body(32'h2000, 0, 2'd2, 4'h3, line, 1);
    wr_resp(2, 0);

    // uncached write, half-word strobe
    line = rand_line();
    wr_accept(32'h1FC0_0006, 1, 2'd1, 4'b1100, line);
    wr_body(32'h1FC0_0006, 1, 2'd1, 4'b1100, line, 0);
    wr_resp(0, 0);

    // read to a line with a write in flight stalls until the write completes
    line = rand_line();
    wr_accept(32'h3000, 0, 2'd2, 4'h0, line);
    addr_r = 32'h3010; req_r = 1'b1; #1;
    chk("hz_addrOK_r", addrOK_r, 0);
    tick();
    chk("hz_addrOK_r_aw", addrOK_r, 0);
    wr_body(32'h3000, 0, 2'd2, 4'h0, line, 0);
    wr_resp(3, 1);
    chk("hz_release", addrOK_r, 1);
    rd_accept(32'h3010, 0, 2'd2);
    rd_body(32'h3010, 0, 2'd2, 1, -1, 0);

    // simultaneous requests to different lines: both accepted
    line = rand_line();
    addr_r = 32'h4000; addr_w = 32'h5000; dout = line; suc = 1'b0;
    req_r = 1'b1; req_w = 1'b1; #1;
    chk("both_addrOK_r", addrOK_r, 1);
    chk("both_addrOK_w", addrOK_w, 1);
    tick();
    req_r = 1'b0; req_w = 1'b0; dout = '0; #1;
    rd_body(32'h4000, 0, 2'd0, 0, -1, 0);
    wr_body(32'h5000, 0, 2'd0, 4'h0, line, 0);
    wr_resp(1, 0);

    // simultaneous requests to the same line: only the write is accepted
    line = rand_line();
    addr_r = 32'h6000; addr_w = 32'h6004; dout = line; suc = 1'b0;
    req_r = 1'b1; req_w = 1'b1; #1;
    chk("same_addrOK_w", addrOK_w, 1);
    chk("same_addrOK_r", addrOK_r, 0);
    tick();
    req_w = 1'b0; dout = '0; #1;
    chk("same_addrOK_r_after", addrOK_r, 0);
    wr_body(32'h6004, 0, 2'd0, 4'h0, line, 1);
    wr_resp(0, 1);
    rd_accept(32'h6000, 0, 2'd2);
    rd_body(32'h6000, 0, 2'd2, 0, -1, 0);

    // reset on beat 4 of a cached read, then a clean read
    rd_accept(32'h7000, 0, 2'd2);
    rd_body(32'h7000, 0, 2'd2, 0, 4, 0);
    rd_accept(32'h7100, 0, 2'd2);
    rd_body(32'h7100, 0, 2'd2, 0, -1, 0);

    // randomized mix of reads and writes
    for (int it = 0; it < 12; it++) begin
      a = $urandom; s = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 2));
      if (!s) a[4:0] = 5'd0;
      if ($urandom_range(0, 1) == 0) begin
        rd_accept(a, s, sz);
        rd_body(a, s, sz, $urandom_range(0, 3), -1, 0);
      end else begin
        line2 = rand_line(); st = 4'($urandom);
        b = a;
        wr_accept(b, s, sz, st, line2);
        wr_body(b, s, sz, st, line2, 0);
        wr_resp($urandom_range(0, 2), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l2cache_axi_bridge.md
L2CACHE_AXI_BRIDGE -- requirements
Module: l2cache_axi_bridge

Interface
REQ-001 SHALL have parameter OFFSET_WIDTH, default 3, giving line beats BEATS=1<<OFFSET_WIDTH and line width LW=32*BEATS (256).
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock for all state.
REQ-003 rst input 1: asynchronous active-high reset.
REQ-004 addr_l2cache_mem_r input 32: read address; line-aligned when cached, byte address when SUC.
REQ-005 addr_l2cache_mem_w input 32: write address; line-aligned when cached, byte address when SUC.
REQ-006 dout_l2cache_mem input LW: write line; only bits [31:0] are used when SUC.
REQ-007 l2cache_mem_req_r / l2cache_mem_req_w input 1 each: read / write request, held until the matching addrOK.
REQ-008 l2cache_mem_rdy input 1: L2 is able to accept read data this cycle.
REQ-009 l2cache_mem_SUC input 1: strongly-uncached single access; l2cache_mem_wstrb input 4 and l2cache_mem_size input 2 apply to SUC only.
REQ-010 din_mem_l2cache output LW: returned read line.
REQ-011 mem_l2cache_addrOK_r / mem_l2cache_addrOK_w output 1 each: request accepted this cycle.
REQ-012 mem_l2cache_dataOK output 1: din_mem_l2cache valid, one-cycle pulse.
REQ-013 AXI AR channel: araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-014 AXI R channel: rdata in 32, rlast in 1, rvalid in 1, rready out 1.
REQ-015 AXI AW channel: awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1.
REQ-016 AXI W channel: wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1.
REQ-017 AXI B channel: bvalid in 1, bready out 1; bresp and rresp are not ports.

Function
REQ-018 SHALL run independent read and write FSMs, each with at most one transaction outstanding.
REQ-019 Read FSM: R_IDLE -> R_AR when req_r is accepted; R_AR -> R_DATA on arvalid&&arready; R_DATA -> R_DONE on the rvalid&&rlast beat; R_DONE -> R_IDLE in the cycle rdy=1, with dataOK=1 in that cycle.
REQ-020 addrOK_r SHALL be combinational and equal to req_r && R_IDLE && !hazard; address, SUC and size SHALL be captured on that edge.
REQ-021 Hazard SHALL be asserted when the write FSM is not W_IDLE and the captured write address bits [31:OFFSET_WIDTH+2] equal the same bits of addr_r; reads stall until the write leaves W_RESP.
REQ-022 Cached read: arlen=BEATS-1, arsize=2, arburst=INCR; beat k SHALL fill din bits [32k+31:32k] using a beat counter that wraps 0..BEATS-1.
REQ-023 SUC read: arlen=0, arsize=size, arburst=INCR; rdata SHALL go to din[31:0] and all upper bits SHALL be 0.
REQ-024 rready SHALL be 1 only in R_DATA; din_mem_l2cache SHALL hold its value from R_DONE until the next R_DATA beat.
REQ-025 Write FSM: W_IDLE -> W_AW when req_w is accepted (addrOK_w = req_w && W_IDLE), capturing address, line, SUC, wstrb and size; W_AW -> W_DATA on awready; W_DATA -> W_RESP on the wready&&wlast beat; W_RESP -> W_IDLE on bvalid (bready=1 only in W_RESP).
REQ-026 Cached write: awlen=BEATS-1, awsize=2, wstrb=4'hF; beat k drives line word k; wlast=1 on beat BEATS-1.
REQ-027 SUC write: awlen=0, awsize=size, wdata=line[31:0], wstrb=captured wstrb, wlast=1.
REQ-028 If req_r and req_w arrive in the same cycle, both SHALL be accepted unless the hazard is true, in which case only the write is accepted.
REQ-029 arvalid, awvalid and wvalid, once asserted, SHALL hold with stable payload until their handshake completes.
REQ-030 rresp and bresp errors SHALL be ignored; the transaction completes normally.

Reset
REQ-031 rst SHALL force both FSMs to IDLE, beat counters to 0, din_mem_l2cache to 0, and all valid, ready, addrOK and dataOK outputs to 0 immediately, including mid-burst; no partial transaction resumes after reset.

Structure
REQ-032 Package l2_axi_pkg SHALL hold the read and write FSM state enums plus the AXI_BURST_INCR and AXI_SIZE_WORD constants.
REQ-033 The line-to-beat serializer SHALL be a sub-module, l2cache_axi_wser (captured line plus beat counter, driving wdata and wlast); the deserializer SHALL stay inline.

Verification
REQ-034 Cached read 0x1000, arready=1, 8 beats 0..7 with rlast on beat 7, rdy=1 -> arlen=7, dataOK pulses one cycle after the last beat, din word k = k.
REQ-035 SUC read 0xBFAF8000, size=2, rdata=0xDEADBEEF -> arlen=0, arsize=2, din=0x...0000DEADBEEF.
REQ-036 Cached write 0x2000 while wready toggles 1,0,1... -> 8 beats in order, wlast only on beat 7, bready only after wlast, FSM returns to W_IDLE on bvalid.
REQ-037 Write to 0x3000 pending, read to 0x3010 requested -> addrOK_r=0 until bvalid; then the read is accepted.
REQ-038 Read with rdy=0 for 5 cycles after rlast -> dataOK stays 0, then pulses once in the cycle rdy rises, with din stable throughout.
REQ-039 rst asserted on beat 4 of a cached read -> rready, arvalid and dataOK drop to 0 at once; a new read afterwards completes correctly.
